queens_board_uart: RTL and testbench
====================================

# queens_board_uart

Downstream readout stage for the N-queens solver. On a start pulse it scans the solver's column-to-row query port and sends the board as ASCII text over a UART transmit line. It then appends the solution count as an unsigned decimal number. It lives in the board top level between the solver and the board's USB-UART pin.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4
- NW, 5, width of n, row_query and row_result
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy=1
- n  in  NW  board size, sampled when start is accepted
- result  in  32  solution count, sampled when start is accepted
- row_query  out  NW  column index presented to the solver
- row_result  in  NW  solver's row for row_query (combinational from row_query)
- tx  out  1  UART line, 8N1, LSB first, idle high
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last stop bit

## Operation
- Reset values: tx=1, busy=0, done=0, row_query=0. All state, counters and the BCD register clear.
- start=1 in IDLE: latch n into n_q and result into res_q, then enter BOARD. Inputs are not sampled again until the next start.
- BOARD: outer loop over r = 0..n_q-1, inner loop over c = 0..n_q-1.
  - Drive row_query=c, then sample row_result one cycle later.
  - Send 'Q' (0x51) if row_result==r, otherwise '.' (0x2E).
  - After each row, send CR (0x0D) then LF (0x0A).
  - n_q==0 skips BOARD entirely.
- CONV: 32-cycle shift-add-3 conversion of res_q into 10 BCD digits.
- DIGITS: send digits most-significant first, with leading zeros suppressed. res_q==0 sends the single digit '0'. Each digit is sent as 0x30+d.
- EOL: send CR, LF. Then pulse done and return to IDLE.
- Total bytes per dump: n_q*(n_q+2) + digit count + 2.
- Byte handoff to the transmitter uses valid/ready. A byte is transferred on the cycle both are high.
- Reset mid-operation: tx returns high immediately (asynchronous). The dump is abandoned, done is not pulsed, and the next start restarts from r=0, c=0.
- Consistency of row_result is the top level's responsibility: issue start only after the solver has finished.

## Timing
- start accepted at edge k:
  - busy=1 and row_query=0 from k+1.
  - First byte handed to the transmitter at k+2.
  - tx falls (start bit) at k+3.
- Each UART frame is exactly 10*CLKS_PER_BIT cycles: 1 start bit, 8 data bits, 1 stop bit.
- Back-to-back frames: the next start bit begins no more than 2 cycles after the previous stop bit ends.
- CONV adds 32–34 cycles between the last board byte and the first digit. During CONV, tx stays high.
- done pulses 1 cycle after the last stop bit ends. busy falls on the same edge.
- A start arriving in the same cycle as done is ignored.

## Structure
- The shared queens package holds:
  - NW
  - ASCII constants: CH_Q, CH_DOT, CH_CR, CH_LF, CH_0
  - the state enum: IDLE, BOARD, CONV, DIGITS, EOL
- Sub-module uart_tx, parameterised by CLKS_PER_BIT.
  - Ports: clk, reset_n, data[7:0], valid, ready, tx.
  - ready is high only when idle; it rises in the cycle after the stop bit ends.
- The top FSM owns the loop counters, the BCD register and the byte mux.

## Test plan
- n=4, result=2, solver model row = (1,3,0,2), CLKS_PER_BIT=4 -> bytes "..Q.\r\nQ...\r\n...Q\r\n.Q..\r\n2\r\n" (27 bytes); done pulses once.
- n=0, result=0 -> "0\r\n" only; row_query stays 0 throughout.
- n=1, result=0xFFFFFFFF, row=(0) -> "Q\r\n4294967295\r\n".
- start pulsed every cycle during a dump -> exactly one dump; busy stays high continuously.
- reset_n low mid-frame -> tx=1 in the same cycle, busy=0, no done; a new start gives a correct full dump.
- Frame timing: each start bit to the next start bit within a line is 40–42 cycles at CLKS_PER_BIT=4, and each bit holds for exactly 4 cycles.

Source files
------------

// File: rtl/queens_board_uart_pkg.sv
// Shared definitions for the N-queens readout path.
//   NW            : width of board size / row / column indices
//   CH_*          : ASCII bytes emitted by the board dump
//   state_e       : top-level readout FSM states
//   sel_e         : byte selector within a board row and the trailing EOL
//   bcd_step      : one shift-add-3 iteration of binary-to-BCD conversion
//   msd_index     : index of the most significant non-zero BCD digit
package queens_board_uart_pkg;

    localparam int unsigned NW = 5;

    localparam logic [7:0] CH_Q   = 8'h51;
    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_0   = 8'h30;

    typedef enum logic [2:0] {IDLE, BOARD, CONV, DIGITS, EOL} state_e;

    typedef enum logic [1:0] {SEL_CELL, SEL_CR, SEL_LF, SEL_WAIT} sel_e;

    // Add 3 to every digit >= 5, then shift left by one, inserting bit_in.
    function automatic logic [39:0] bcd_step(input logic [39:0] b, input logic bit_in);
        logic [39:0] a;
        a = b;
        for (int unsigned i = 0; i < 10; i++) begin
            if (b[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return 40'({a, bit_in});
    endfunction

    // Zero value yields index 0 so a lone '0' digit is still sent.
    function automatic logic [3:0] msd_index(input logic [39:0] b);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (b[i*4 +: 4] != 4'd0) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/queens_board_uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high.
//   clk, reset_n : clock, asynchronous active-low reset
//   data, valid  : byte to send; accepted on a cycle with valid && ready
//   ready        : high only while idle (rises the cycle after a stop bit ends)
//   tx           : serial line
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    tx_state_e     st, st_nxt;
    logic [8:0]    shreg;     // remaining data bits followed by the stop bit
    logic [3:0]    bit_cnt;   // 0 = start bit, 9 = stop bit
    logic [CW-1:0] clk_cnt;

    assign ready = (st == TX_IDLE);

    always_comb begin
        st_nxt = st;
        case (st)
            TX_IDLE: if (valid) st_nxt = TX_SEND;
            TX_SEND: if (clk_cnt == LAST && bit_cnt == 4'd9) st_nxt = TX_IDLE;
            default: st_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= TX_IDLE;
        else          st <= st_nxt;
    end

    // Start bit is driven on the accepting edge itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx      <= 1'b1;
            shreg   <= '1;
            bit_cnt <= '0;
            clk_cnt <= '0;
        end else if (st == TX_IDLE) begin
            if (valid) begin
                tx      <= 1'b0;
                shreg   <= {1'b1, data};
                bit_cnt <= '0;
                clk_cnt <= '0;
            end
        end else if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/queens_board_uart.sv
// Dumps the N-queens board and solution count as ASCII over a UART.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle request, ignored while busy (and in the done cycle)
//   n, result    : board size and solution count, latched on start
//   row_query    : column presented to the solver
//   row_result   : solver's row for row_query (combinational)
//   tx           : UART line, 8N1
//   busy, done   : dump in progress / one-cycle completion pulse
module queens_board_uart
    import queens_board_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [31:0]   result,
    output logic [NW-1:0] row_query,
    input  logic [NW-1:0] row_result,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    state_e        state, state_nxt;
    sel_e          sel;
    logic [NW-1:0] n_q, r_q, c_q, n_last;
    logic [31:0]   res_q;
    logic [39:0]   bcd_q, bcd_nxt;
    logic [4:0]    step_q;
    logic [3:0]    di_q;
    logic          primed;  // row_query has been stable for a cycle
    logic          tx_valid, tx_ready, xfer;
    logic [7:0]    tx_data;

    assign n_last    = n_q - NW'(1);
    assign row_query = c_q;
    assign busy      = (state != IDLE);
    assign xfer      = tx_valid && tx_ready;
    assign bcd_nxt   = bcd_step(bcd_q, res_q[31]);

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = CH_CR;
        case (state)
            IDLE: if (start && !done) state_nxt = BOARD;
            BOARD: begin
                if (n_q == '0) begin
                    state_nxt = CONV;
                end else begin
                    tx_valid = primed;
                    case (sel)
                        SEL_CELL: tx_data = (row_result == r_q) ? CH_Q : CH_DOT;
                        SEL_CR:   tx_data = CH_CR;
                        default:  tx_data = CH_LF;
                    endcase
                    if (primed && tx_ready && sel == SEL_LF && r_q == n_last)
                        state_nxt = CONV;
                end
            end
            // Conversion only advances once the last board frame has left the line.
            CONV: if (tx_ready && step_q == 5'd31) state_nxt = DIGITS;
            DIGITS: begin
                tx_valid = 1'b1;
                tx_data  = CH_0 + {4'b0000, bcd_q[{di_q, 2'b00} +: 4]};
                if (tx_ready && di_q == '0) state_nxt = EOL;
            end
            EOL: begin
                tx_valid = (sel != SEL_WAIT);
                tx_data  = (sel == SEL_CR) ? CH_CR : CH_LF;
                if (sel == SEL_WAIT && tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q    <= '0;
            res_q  <= '0;
            r_q    <= '0;
            c_q    <= '0;
            sel    <= SEL_CELL;
            primed <= 1'b0;
            bcd_q  <= '0;
            step_q <= '0;
            di_q   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    primed <= 1'b0;
                    if (start && !done) begin
                        n_q    <= n;
                        res_q  <= result;
                        r_q    <= '0;
                        c_q    <= '0;
                        sel    <= SEL_CELL;
                        bcd_q  <= '0;
                        step_q <= '0;
                    end
                end
                BOARD: begin
                    primed <= 1'b1;
                    if (xfer) begin
                        case (sel)
                            SEL_CELL: begin
                                if (c_q == n_last) begin
                                    c_q <= '0;
                                    sel <= SEL_CR;
                                end else begin
                                    c_q <= c_q + NW'(1);
                                end
                            end
                            SEL_CR: sel <= SEL_LF;
                            default: begin
                                sel <= SEL_CELL;
                                if (r_q != n_last) r_q <= r_q + NW'(1);
                            end
                        endcase
                    end
                end
                CONV: begin
                    if (tx_ready) begin
                        bcd_q  <= bcd_nxt;
                        res_q  <= {res_q[30:0], 1'b0};
                        step_q <= step_q + 5'd1;
                        if (step_q == 5'd31) di_q <= msd_index(bcd_nxt);
                    end
                end
                DIGITS: begin
                    if (xfer) begin
                        if (di_q == '0) sel <= SEL_CR;
                        else            di_q <= di_q - 4'd1;
                    end
                end
                EOL: begin
                    if (xfer)                             sel  <= (sel == SEL_CR) ? SEL_LF : SEL_WAIT;
                    else if (sel == SEL_WAIT && tx_ready) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (tx_data),
        .valid   (tx_valid),
        .ready   (tx_ready),
        .tx      (tx)
    );

endmodule

// File: tb/tb_queens_board_uart.sv
// Scoreboarded bench: stimulus pushes the expected byte stream (from a
// string-level model of the dump), a UART receiver pops and compares.
module tb_queens_board_uart;
    import queens_board_uart_pkg::*;

    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] n_in = '0;
    logic [31:0]   res_in = '0;
    logic [NW-1:0] row_query, row_result;
    logic          tx, busy, done;

    logic [NW-1:0] sol [0:31];

    typedef struct {
        logic [7:0] ch;
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_err = 0, done_cnt = 0, cyc = 0, rx_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    assign row_result = sol[row_query];

    queens_board_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .n          (n_in),
        .result     (res_in),
        .row_query  (row_query),
        .row_result (row_result),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic void push_b(input logic [7:0] ch, input int lo, input int hi);
        exp_t e;
        e.ch = ch;
        e.lo = lo;
        e.hi = hi;
        sb.push_back(e);
    endfunction

    // Expected text: board rows, CRLF per row, decimal count, CRLF.
    // Gap tags give the allowed start-bit-to-start-bit distance from the previous byte.
    function automatic int build_expected(input int nn, input logic [31:0] rr);
        string s;
        bit    first;
        s = $sformatf("%0d", rr);
        first = 1'b1;
        for (int r = 0; r < nn; r++) begin
            for (int c = 0; c < nn; c++) begin
                push_b((sol[c] == NW'(r)) ? 8'h51 : 8'h2E, first ? 0 : 40, 42);
                first = 1'b0;
            end
            push_b(8'h0D, 40, 42);
            push_b(8'h0A, 40, 42);
        end
        for (int i = 0; i < s.len(); i++) begin
            if (i == 0) push_b(s[i], (nn != 0) ? 72 : 0, 76);
            else        push_b(s[i], 40, 42);
        end
        push_b(8'h0D, 40, 42);
        push_b(8'h0A, 40, 42);
        return nn * (nn + 2) + s.len() + 2;
    endfunction

    initial begin : monitor
        int         prev_start, st, hold_err;
        logic [9:0] bits;
        bit         aborted;
        exp_t       e;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                aborted = 1'b0;
                hold_err = 0;
                bits = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < CPB && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (reset_n !== 1'b1) aborted = 1'b1;
                        else if (s == 0) bits[b] = tx;
                        else if (tx !== bits[b]) hold_err++;
                    end
                end
                if (!aborted) begin
                    rx_cnt++;
                    chk("stop_bit", 32'(bits[9]), 32'd1);
                    chk("bit_hold", hold_err, 0);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %02h expected none", bits[8:1]);
                    end else begin
                        e = sb.pop_front();
                        chk("byte", 32'(bits[8:1]), 32'(e.ch));
                        if (e.lo != 0) chk_rng("frame_gap", st - prev_start, e.lo, e.hi);
                    end
                    prev_start = st;
                end
            end
        end
    end

    task automatic run_dump(input int nn, input logic [31:0] rr, input bit spam);
        int nbytes, rx0, dc0, lim, busy_drop, rq_nz;
        bit seen;
        nbytes = build_expected(nn, rr);
        rx0 = rx_cnt;
        dc0 = done_cnt;
        @(negedge clk);
        n_in = NW'(nn);
        res_in = rr;
        start = 1'b1;
        @(posedge clk); #1;
        if (!spam) start = 1'b0;
        chk("busy_k1", 32'(busy), 32'd1);
        chk("row_query_k1", 32'(row_query), 32'd0);
        chk("tx_k1", 32'(tx), 32'd1);
        @(posedge clk); #1;
        chk("tx_k2", 32'(tx), 32'd1);
        @(posedge clk); #1;
        if (nn != 0) chk("tx_k3", 32'(tx), 32'd0);
        lim = nbytes * (10 * CPB + 4) + 200;
        busy_drop = 0;
        rq_nz = 0;
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy !== 1'b1) busy_drop++;
                if (row_query != '0) rq_nz++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("busy_continuous", busy_drop, 0);
        if (nn == 0) chk("row_query_zero", rq_nz, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("done_count", done_cnt - dc0, 1);
        chk("byte_count", rx_cnt - rx0, nbytes);
        chk("queue_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  nn, dc;
        bit  found;
        logic [31:0] rr;
        for (int i = 0; i < 32; i++) sol[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_row_query", 32'(row_query), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        sol[0] = 5'd1; sol[1] = 5'd3; sol[2] = 5'd0; sol[3] = 5'd2;
        run_dump(4, 32'd2, 1'b0);
        run_dump(0, 32'd0, 1'b0);
        sol[0] = 5'd0;
        run_dump(1, 32'hFFFF_FFFF, 1'b0);
        sol[0] = 5'd1;
        run_dump(4, 32'd1234, 1'b1);

        // Reset in the middle of a frame.
        void'(build_expected(4, 32'd7));
        @(negedge clk);
        n_in = NW'(4);
        res_in = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) found = 1'b1;
        end
        chk("tx_low_found", 32'(found), 32'd1);
        dc = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_mid_tx", 32'(tx), 32'd1);
        chk("reset_mid_busy", 32'(busy), 32'd0);
        chk("reset_mid_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        sb.delete();
        repeat (50) @(posedge clk);
        chk("no_done_after_reset", done_cnt - dc, 0);
        run_dump(4, 32'd7, 1'b0);

        for (int t = 0; t < 5; t++) begin
            nn = $urandom_range(0, 6);
            for (int c = 0; c < nn; c++) sol[c] = NW'($urandom_range(0, nn - 1));
            case ($urandom_range(0, 2))
                0:       rr = 32'($urandom_range(0, 9));
                1:       rr = $urandom;
                default: rr = 32'($urandom_range(0, 99999));
            endcase
            run_dump(nn, rr, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
